tdc_evt_buf: RTL and testbench

TDC_EVT_BUF -- requirements
Module: tdc_evt_buf

---
 rtl/tdc_pkg.sv | 18 +
 rtl/tdc_sync_fifo.sv | 50 +++++
 rtl/tdc_evt_buf.sv | 115 +++++++++++
 tb/tb_tdc_evt_buf.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC types and default widths for the event buffer.
// tdc_word_t is the {tag, result} word layout presented on rd_data.
package tdc_pkg;

    localparam int TDC_DATA_W = 16;
    localparam int TDC_TS_W   = 8;

    typedef struct packed {
        logic [TDC_TS_W-1:0]   tag;
        logic [TDC_DATA_W-1:0] result;
    } tdc_word_t;

    // Drop counter saturates instead of wrapping so software can tell "many" from "few".
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Storage and wrap-bit pointers for the TDC event buffer.
// Admission decisions are made by the caller; this block only moves pointers.
module tdc_sync_fifo
    import tdc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = TDC_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     clr,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    // The extra top bit flips on each lap so equal indices can mean either full or empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tdc_evt_buf.sv
// TDC result buffer: FIFO admission, overflow tracking, interrupts and optional timestamp tags.
// Define TDC_TIMESTAMP_EN to tag each stored result with a free-running cycle count.
module tdc_evt_buf
    import tdc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = TDC_DATA_W,
    parameter int TS_W   = TDC_TS_W
) (
    input  logic                     clk_osc,
    input  logic                     rst,
    input  logic                     res_valid,
    input  logic [DATA_W-1:0]        res_data,
    input  logic                     rd_req,
    output logic [DATA_W+TS_W-1:0]   rd_data,
    output logic                     rd_valid,
    input  logic [$clog2(DEPTH):0]   thr,
    input  logic                     ovf_clr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt,
    output logic                     INT0,
    output logic                     INT1
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef TDC_TIMESTAMP_EN
    localparam int ST_W = DATA_W + TS_W;
`else
    localparam int ST_W = DATA_W;
`endif

    logic            do_push;
    logic            do_pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ovf_flag;
    logic [ST_W-1:0] wr_word;
    logic [ST_W-1:0] head;
    logic [TS_W-1:0] tag_out;
    logic [CW-1:0]   thr_eff;

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts when read.
    assign do_pop  = rd_req && !fifo_empty && !flush;
    assign do_push = res_valid && !flush && (!fifo_full || do_pop);
    assign drop    = res_valid && !flush && fifo_full && !do_pop;

    tdc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ST_W)
    ) u_fifo (
        .clk     (clk_osc),
        .rst     (rst),
        .wr_en   (do_push),
        .rd_en   (do_pop),
        .clr     (flush),
        .wr_data (wr_word),
        .head    (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef TDC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 1'b1;
    end

    assign wr_word = {ts_cnt, res_data};
    assign tag_out = head[ST_W-1:DATA_W];
`else
    assign wr_word = res_data;
    assign tag_out = '0;
`endif

    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) rd_data <= {tag_out, head[DATA_W-1:0]};
        end
    end

    // A drop coinciding with ovf_clr must stay visible, so it restarts the count at one.
    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
            drop_cnt <= ovf_clr ? 8'd1 : sat_inc8(drop_cnt);
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // A zero threshold would hold INT0 high on an empty buffer, so it acts as one.
    assign thr_eff = (thr == '0) ? CW'(1) : thr;

    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) INT0 <= 1'b0;
        else     INT0 <= (count >= thr_eff);
    end

    assign INT1 = ovf_flag;

endmodule

// File: tb/tb_tdc_evt_buf.sv
// Randomised and directed bench for tdc_evt_buf against a queue-based reference model.
// Tag expectations follow TDC_TIMESTAMP_EN when it is defined for the build.
module tb_tdc_evt_buf;
    import tdc_pkg::*;

    localparam int DEPTH = 8;

    logic        clk_osc   = 1'b0;
    logic        rst       = 1'b1;
    logic        res_valid = 1'b0;
    logic [15:0] res_data  = '0;
    logic        rd_req    = 1'b0;
    logic [3:0]  thr       = '0;
    logic        ovf_clr   = 1'b0;
    logic        flush     = 1'b0;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        INT0;
    logic        INT1;

    tdc_evt_buf #(.DEPTH(DEPTH)) dut (
        .clk_osc   (clk_osc),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .thr       (thr),
        .ovf_clr   (ovf_clr),
        .flush     (flush),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .INT0      (INT0),
        .INT1      (INT1)
    );

    always #5 clk_osc = ~clk_osc;

    // Clock edges since reset release; the timestamp a push sees is this value mod 256.
    int cyc;
    always @(posedge clk_osc) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [23:0] q[$];
    logic [23:0] m_rd_data;
    bit          m_rd_valid;
    bit          m_ovf;
    bit          m_int0;
    int          m_drop;
    int          n_checks;
    int          n_fail;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("count", 32'(count), 32'(q.size()));
        checkOutput("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        checkOutput("rd_data", 32'(rd_data), 32'(m_rd_data));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        checkOutput("INT1", 32'(INT1), 32'(m_ovf));
        checkOutput("INT0", 32'(INT0), 32'(m_int0));
    endtask

    function automatic logic [7:0] expTag();
`ifdef TDC_TIMESTAMP_EN
        return 8'(cyc % 256);
`else
        return 8'h00;
`endif
    endfunction

    // One clock of stimulus: the model is advanced from the same inputs, then outputs are compared.
    task automatic applyStimulus(input bit rv, input logic [15:0] d, input bit rq,
                                 input bit oc, input bit fl);
        int old_size;
        int te;
        bit pop;
        bit push;
        bit drop;
        res_valid = rv;
        res_data  = d;
        rd_req    = rq;
        ovf_clr   = oc;
        flush     = fl;
        old_size  = q.size();
        te        = (thr == 0) ? 1 : int'(thr);
        pop = 0; push = 0; drop = 0;
        if (fl) begin
            q.delete();
        end else begin
            pop  = rq && (old_size > 0);
            push = rv && ((old_size < DEPTH) || pop);
            drop = rv && !push;
            if (pop) m_rd_data = q.pop_front();
            if (push) q.push_back({expTag(), d});
        end
        m_rd_valid = pop;
        if (drop) begin
            m_ovf  = 1;
            m_drop = oc ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (oc) begin
            m_ovf  = 0;
            m_drop = 0;
        end
        m_int0 = (old_size >= te);
        @(posedge clk_osc);
        #1;
        res_valid = 0;
        rd_req    = 0;
        ovf_clr   = 0;
        flush     = 0;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 16'h0, 0, 0, 0);
    endtask

    // Reset is raised mid-cycle with a push and pop pending; both must be discarded.
    task automatic doReset();
        #2;
        rst       = 1;
        res_valid = 1;
        res_data  = 16'hBEEF;
        rd_req    = 1;
        #1;
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 0;
        m_ovf      = 0;
        m_int0     = 0;
        m_drop     = 0;
        checkAll();
        @(posedge clk_osc);
        @(posedge clk_osc);
        #1;
        checkAll();
        res_valid = 0;
        rd_req    = 0;
        @(negedge clk_osc);
        rst = 0;
    endtask

    initial begin
        tdc_word_t wa;
        tdc_word_t wb;
        int        guard;
        n_checks = 0;
        n_fail   = 0;

        doReset();

        // Three results read back in order.
        thr = 4'd4;
        applyStimulus(1, 16'h0011, 0, 0, 0);
        applyStimulus(1, 16'h0022, 0, 0, 0);
        applyStimulus(1, 16'h0033, 0, 0, 0);
        checkOutput("cnt_after_3_push", 32'(count), 32'd3);
        applyStimulus(0, 16'h0, 1, 0, 0);
        checkOutput("first_pop", 32'(rd_data[15:0]), 32'h0011);
        applyStimulus(0, 16'h0, 1, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0);
        checkOutput("third_pop", 32'(rd_data[15:0]), 32'h0033);
        checkOutput("cnt_drained", 32'(count), 32'd0);
        applyStimulus(0, 16'h0, 1, 0, 0);

        // INT0 threshold of four, one cycle behind count.
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'(16'h0100 + i), 0, 0, 0);
        checkOutput("int0_lag", 32'(INT0), 32'd0);
        idle(1);
        checkOutput("int0_rise", 32'(INT0), 32'd1);
        applyStimulus(0, 16'h0, 1, 0, 0);
        idle(1);
        checkOutput("int0_fall", 32'(INT0), 32'd0);

        // Fill, overflow by three, drain, then clear the overflow.
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'(16'h0200 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'(16'h0E00 + i), 0, 0, 0);
        checkOutput("drop3", 32'(drop_cnt), 32'd3);
        checkOutput("int1_set", 32'(INT1), 32'd1);
        applyStimulus(1, 16'h0AAA, 1, 0, 0);
        checkOutput("full_pushpop_cnt", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) applyStimulus(0, 16'h0, 1, 0, 0);
        applyStimulus(0, 16'h0, 0, 1, 0);
        checkOutput("ovf_cleared", 32'(drop_cnt), 32'd0);

        // Drop and ovf_clr together: the drop wins.
        for (int i = 0; i < 9; i++) applyStimulus(1, 16'(16'h0300 + i), 0, 0, 0);
        applyStimulus(1, 16'h0F0F, 0, 1, 0);
        checkOutput("drop_beats_clr", 32'(drop_cnt), 32'd1);

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) applyStimulus(1, 16'(i), 0, 0, 0);
        checkOutput("drop_sat", 32'(drop_cnt), 32'd255);

        // Flush at five with a coincident result, then a read on the empty buffer.
        applyStimulus(0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'(16'h0400 + i), 0, 0, 0);
        applyStimulus(1, 16'h0555, 0, 0, 1);
        checkOutput("flush_cnt", 32'(count), 32'd0);
        idle(1);
        checkOutput("flush_int0", 32'(INT0), 32'd0);
        applyStimulus(0, 16'h0, 1, 0, 0);
        checkOutput("empty_read", 32'(rd_valid), 32'd0);

        // Zero threshold behaves as one.
        thr = 4'd0;
        applyStimulus(1, 16'h0777, 0, 0, 0);
        idle(1);
        checkOutput("thr0_int0", 32'(INT0), 32'd1);

        // Timestamp tags: ten cycles apart straight after reset, then across the 255->0 wrap.
        doReset();
        applyStimulus(1, 16'h00A1, 0, 0, 0);
        idle(9);
        applyStimulus(1, 16'h00A2, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0);
        wa = rd_data;
        applyStimulus(0, 16'h0, 1, 0, 0);
        wb = rd_data;
`ifdef TDC_TIMESTAMP_EN
        checkOutput("tag_first", 32'(wa.tag), 32'd0);
        checkOutput("tag_diff", 32'(8'(wb.tag - wa.tag)), 32'd10);
`else
        checkOutput("tag_zero_a", 32'(wa.tag), 32'd0);
        checkOutput("tag_zero_b", 32'(wb.tag), 32'd0);
`endif
        guard = 0;
        while (cyc != 250 && guard < 400) begin
            idle(1);
            guard++;
        end
        checkOutput("wrap_reach", 32'(cyc), 32'd250);
        applyStimulus(1, 16'h00B1, 0, 0, 0);
        idle(9);
        applyStimulus(1, 16'h00B2, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0);
        wa = rd_data;
        applyStimulus(0, 16'h0, 1, 0, 0);
        wb = rd_data;
`ifdef TDC_TIMESTAMP_EN
        checkOutput("tag_wrap", 32'(wb.tag), 32'd4);
        checkOutput("tag_wrap_diff", 32'(8'(wb.tag - wa.tag)), 32'd10);
`else
        checkOutput("tag_wrap_zero", 32'(wb.tag), 32'd0);
`endif

        // Random traffic with alternating fill-heavy and drain-heavy phases.
        for (int i = 0; i < 1500; i++) begin
            bit rv;
            bit rq;
            if (i % 97 == 0) thr = 4'($urandom_range(0, DEPTH + 1));
            if ((i / 100) % 2 == 0) begin
                rv = ($urandom_range(0, 9) < 7);
                rq = ($urandom_range(0, 9) < 3);
            end else begin
                rv = ($urandom_range(0, 9) < 3);
                rq = ($urandom_range(0, 9) < 7);
            end
            if (i == 700) doReset();
            applyStimulus(rv, 16'($urandom), rq,
                          ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
